// File: rtl/fc_neuron_sequencer.sv
// Steps one shared 84-input dot-product datapath through N_OUT neurons.
// Ports: clk, rst_n, start, busy, done, w_rd, w_addr, w_row, b_val,
//   dp_weights, dp_bias, dp_result, out_valid, out_ready, out_data, out_idx.
// Optional build macro FC_RELU_EN clamps negative results to zero.
module fc_neuron_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int N_OUT     = 10,
  parameter int DP_LAT    = 0,
  parameter int ADDR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     w_rd,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic [BIT_WIDTH*84-1:0]  w_row,
  input  logic [BIT_WIDTH-1:0]     b_val,
  output logic [BIT_WIDTH*84-1:0]  dp_weights,
  output logic [BIT_WIDTH-1:0]     dp_bias,
  input  logic [OUT_WIDTH-1:0]     dp_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic [ADDR_W-1:0]        out_idx
);

  localparam int CW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);
  localparam logic [CW-1:0]     LAST_CNT = CW'(DP_LAT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SETTLE, EMIT, DONE
  } state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        idx_q;
  logic [CW-1:0]            cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     w_rd_q;
  logic                     valid_q;
  logic [OUT_WIDTH-1:0]     data_q;
  logic [ADDR_W-1:0]        oidx_q;
  logic [BIT_WIDTH*84-1:0]  wts_q;
  logic [BIT_WIDTH-1:0]     bias_q;
  logic [OUT_WIDTH-1:0]     cap_d;

  always_comb begin
`ifdef FC_RELU_EN
    cap_d = dp_result[OUT_WIDTH-1] ? '0 : dp_result;
`else
    cap_d = dp_result;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_rd_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
      wts_q   <= '0;
      bias_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            w_rd_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          w_rd_q  <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          wts_q   <= w_row;
          bias_q  <= b_val;
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == LAST_CNT) begin
            data_q  <= cap_d;
            oidx_q  <= idx_q;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              w_rd_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign w_rd       = w_rd_q;
  assign w_addr     = idx_q;
  assign dp_weights = wts_q;
  assign dp_bias    = bias_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_idx    = oidx_q;

endmodule

// File: tb/tb_fc_neuron_sequencer.sv
// Bench for fc_neuron_sequencer: three instances (N/LAT = 10/0, 3/2, 1/0)
// checked every cycle against a schedule model plus literal expectations.
module tb_fc_neuron_sequencer;
  localparam int BW = 32;
  localparam int OW = 64;
  localparam int AW = 4;
  localparam int RW = 84 * BW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic st [3];
  logic rdy [3];
  bit   neg_mode;

  logic          busy [3], done_ [3], w_rd [3], out_valid [3];
  logic [AW-1:0] w_addr [3], out_idx [3], raddr [3];
  logic [RW-1:0] w_row [3], dp_w [3];
  logic [BW-1:0] b_val [3], dp_b [3];
  logic [OW-1:0] dp_res [3], out_data [3];
  logic [OW-1:0] p1, p2;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  bit act [3], dn [3];
  int k [3], off [3];
  bit ff_seen [3];
  int ff_cyc [3], ff_addr [3], done_cnt [3], done_cyc [3];
  logic [OW-1:0] hs_q [$];

  function automatic int nout(input int i);
    case (i)
      0: return 10;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int lat(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic logic [RW-1:0] row_of(input int a);
    logic [RW-1:0] r;
    for (int j = 0; j < 84; j++) r[j*BW +: BW] = 32'(a * 1000 + j);
    return r;
  endfunction

  function automatic logic [BW-1:0] bias_of(input int a);
    if (neg_mode && a == 2) return 32'hFFFF_FFFB;
    return 32'(a * 100 + 7);
  endfunction

  function automatic logic [OW-1:0] sx(input logic [BW-1:0] b);
    return {{(OW-BW){b[BW-1]}}, b};
  endfunction

  function automatic logic [OW-1:0] exp_out(input int a);
    logic [OW-1:0] v;
    v = sx(bias_of(a));
`ifdef FC_RELU_EN
    if (v[OW-1]) v = '0;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) if (w_rd[i]) raddr[i] <= w_addr[i];
    p1 <= sx(dp_b[1]);
    p2 <= p1;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_row[i] = row_of(int'(raddr[i]));
      b_val[i] = bias_of(int'(raddr[i]));
    end
    dp_res[0] = sx(dp_b[0]);
    dp_res[1] = p2;
    dp_res[2] = sx(dp_b[2]);
  end

  fc_neuron_sequencer #(.N_OUT(10), .DP_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(busy[0]),
    .done(done_[0]), .w_rd(w_rd[0]), .w_addr(w_addr[0]),
    .w_row(w_row[0]), .b_val(b_val[0]), .dp_weights(dp_w[0]),
    .dp_bias(dp_b[0]), .dp_result(dp_res[0]), .out_valid(out_valid[0]),
    .out_ready(rdy[0]), .out_data(out_data[0]), .out_idx(out_idx[0]));

  fc_neuron_sequencer #(.N_OUT(3), .DP_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(busy[1]),
    .done(done_[1]), .w_rd(w_rd[1]), .w_addr(w_addr[1]),
    .w_row(w_row[1]), .b_val(b_val[1]), .dp_weights(dp_w[1]),
    .dp_bias(dp_b[1]), .dp_result(dp_res[1]), .out_valid(out_valid[1]),
    .out_ready(rdy[1]), .out_data(out_data[1]), .out_idx(out_idx[1]));

  fc_neuron_sequencer #(.N_OUT(1), .DP_LAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .busy(busy[2]),
    .done(done_[2]), .w_rd(w_rd[2]), .w_addr(w_addr[2]),
    .w_row(w_row[2]), .b_val(b_val[2]), .dp_weights(dp_w[2]),
    .dp_bias(dp_b[2]), .dp_result(dp_res[2]), .out_valid(out_valid[2]),
    .out_ready(rdy[2]), .out_data(out_data[2]), .out_idx(out_idx[2]));

  task automatic cmp(input string nm, input int i,
                     input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s u%0d cyc %0d: got %h expected %h", nm, i, cyc, a, e);
    end
  endtask

  task automatic cmpw(input string nm, input int i,
                      input logic [RW-1:0] a, input logic [RW-1:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      for (int j = 0; j < 84; j++)
        if (a[j*BW +: BW] !== e[j*BW +: BW]) begin
          $display("FAIL %s u%0d cyc %0d word %0d: got %h expected %h",
                   nm, i, cyc, j, a[j*BW +: BW], e[j*BW +: BW]);
          break;
        end
    end
  endtask

  task automatic chk(input int i);
    bit ewr, ev;
    if (!rst_n) begin
      act[i] = 0;
      dn[i] = 0;
      cmp("rst_busy", i, 64'(busy[i]), 64'd0);
      cmp("rst_done", i, 64'(done_[i]), 64'd0);
      cmp("rst_w_rd", i, 64'(w_rd[i]), 64'd0);
      cmp("rst_w_addr", i, 64'(w_addr[i]), 64'd0);
      cmp("rst_valid", i, 64'(out_valid[i]), 64'd0);
      cmp("rst_data", i, out_data[i], 64'd0);
      cmp("rst_idx", i, 64'(out_idx[i]), 64'd0);
      cmp("rst_bias", i, 64'(dp_b[i]), 64'd0);
      cmpw("rst_wts", i, dp_w[i], '0);
      return;
    end
    ewr = act[i] && off[i] == 0;
    ev  = act[i] && off[i] >= 3 + lat(i);
    cmp("busy", i, 64'(busy[i]), 64'(act[i] || dn[i]));
    cmp("done", i, 64'(done_[i]), 64'(dn[i]));
    cmp("w_rd", i, 64'(w_rd[i]), 64'(ewr));
    cmp("out_valid", i, 64'(out_valid[i]), 64'(ev));
    if (ewr) cmp("w_addr", i, 64'(w_addr[i]), 64'(k[i]));
    if (ev) begin
      cmp("out_data", i, out_data[i], exp_out(k[i]));
      cmp("out_idx", i, 64'(out_idx[i]), 64'(k[i]));
    end
    if (act[i] && off[i] >= 2) begin
      cmpw("dp_weights", i, dp_w[i], row_of(k[i]));
      cmp("dp_bias", i, 64'(dp_b[i]), 64'(bias_of(k[i])));
    end
    if (w_rd[i] && !ff_seen[i]) begin
      ff_seen[i] = 1;
      ff_cyc[i] = cyc;
      ff_addr[i] = int'(w_addr[i]);
    end
    if (done_[i]) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
    end
    if (i == 0 && out_valid[0] && rdy[0]) hs_q.push_back(out_data[0]);
    if (dn[i]) dn[i] = 0;
    else if (!act[i]) begin
      if (st[i]) begin
        act[i] = 1;
        k[i] = 0;
        off[i] = 0;
      end
    end else if (off[i] >= 3 + lat(i)) begin
      if (rdy[i]) begin
        if (k[i] == nout(i) - 1) begin
          act[i] = 0;
          dn[i] = 1;
        end else begin
          k[i]++;
          off[i] = 0;
        end
      end
    end else off[i]++;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) chk(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      ff_seen[i] = 0;
      done_cnt[i] = 0;
    end
    hs_q.delete();
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done_cnt[i] == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt[i] == 0) begin
      nvec++;
      nfail++;
      $display("FAIL done_timeout u%0d: got no done expected one", i);
    end
    tick();
  endtask

  task automatic wait_cond0(input int addr, input bit emit, input int budget);
    int n = 0;
    while (n < budget &&
           !(emit ? (out_valid[0] && int'(out_idx[0]) == addr)
                  : (w_rd[0] && int'(w_addr[0]) == addr))) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      nvec++;
      nfail++;
      $display("FAIL wait_timeout addr %0d: got none expected event", addr);
    end
  endtask

  task automatic chk_hs(input int idx, input logic [63:0] e);
    if (hs_q.size() > idx) cmp("hs_word", idx, hs_q[idx], e);
    else cmp("hs_count", idx, 64'(hs_q.size()), 64'(idx + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] relu_exp;
`ifdef FC_RELU_EN
    relu_exp = 64'd0;
`else
    relu_exp = 64'hFFFF_FFFF_FFFF_FFFB;
`endif
    rst_n = 1'b0;
    neg_mode = 0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (10) tick();

    clr();
    for (int i = 0; i < 3; i++) st[i] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (8) tick();
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_done(0, 200);
    repeat (2) tick();
    cmp("pass_len", 0, 64'(done_cyc[0] - ff_cyc[0] + 1), 64'd41);
    cmp("pass_len", 1, 64'(done_cyc[1] - ff_cyc[1] + 1), 64'd19);
    cmp("pass_len", 2, 64'(done_cyc[2] - ff_cyc[2] + 1), 64'd5);
    for (int i = 0; i < 3; i++) cmp("done_cnt", i, 64'(done_cnt[i]), 64'd1);
    cmp("hs_size", 0, 64'(hs_q.size()), 64'd10);
    chk_hs(0, 64'd7);
    chk_hs(3, 64'd307);
    chk_hs(9, 64'd907);

    clr();
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_cond0(3, 1, 100);
    rdy[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cmp("bp_data", 0, out_data[0], 64'd307);
      cmp("bp_idx", 0, 64'(out_idx[0]), 64'd3);
      cmp("bp_valid", 0, 64'(out_valid[0]), 64'd1);
      cmp("bp_w_rd", 0, 64'(w_rd[0]), 64'd0);
      tick();
    end
    rdy[0] = 1'b1;
    wait_done(0, 200);
    cmp("bp_pass_len", 0, 64'(done_cyc[0] - ff_cyc[0] + 1), 64'd46);
    cmp("bp_hs_size", 0, 64'(hs_q.size()), 64'd10);
    chk_hs(4, 64'd407);

    clr();
    neg_mode = 1;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_done(0, 200);
    chk_hs(2, relu_exp);
    chk_hs(3, 64'd307);
    neg_mode = 0;

    clr();
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_cond0(4, 0, 100);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    cmp("abort_busy", 0, 64'(busy[0]), 64'd0);
    cmp("abort_valid", 0, 64'(out_valid[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    cmp("abort_done", 0, 64'(done_cnt[0]), 64'd0);
    clr();
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_done(0, 200);
    cmp("restart_addr", 0, 64'(ff_addr[0]), 64'd0);
    cmp("restart_len", 0, 64'(done_cyc[0] - ff_cyc[0] + 1), 64'd41);
    cmp("restart_hs", 0, 64'(hs_q.size()), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
